// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states, defaults and hold-register layout for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] PC_INC_DEFAULT = 32'd4;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_out_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: cache request/response and decode handshake bundle
// master = fetch_ctrl side, slave = cache/decode environment side
interface fetch_if #(parameter type T = logic [31:0]);
  logic icache_req_valid;
  logic icache_req_ready;
  T     icache_req_addr;
  logic icache_resp_valid;
  T     icache_resp_data;
  logic out_valid;
  logic out_ready;
  T     out_instr;
  T     out_pc;
  modport master (
    output icache_req_valid, icache_req_addr, out_valid, out_instr, out_pc,
    input  icache_req_ready, icache_resp_valid, icache_resp_data, out_ready
  );
  modport slave (
    input  icache_req_valid, icache_req_addr, out_valid, out_instr, out_pc,
    output icache_req_ready, icache_resp_valid, icache_resp_data, out_ready
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: three saturating 32-bit event counters, cleared by reset
// inputs: clk, reset, fetched/redirected/dropped strobes; outputs: perf_* counts
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetched,
  input  logic        redirected,
  input  logic        dropped,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped
);
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_redirects <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(fetched && !(&perf_fetched));
      perf_redirects <= perf_redirects + 32'(redirected && !(&perf_redirects));
      perf_dropped <= perf_dropped + 32'(dropped && !(&perf_dropped));
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding fetch sequencer between PC generation, icache and decode
// ports: clk, reset (sync, active-high), redirect_valid/redirect_pc, bus (fetch_if.master:
// icache req/resp + decode out handshake); with FETCH_PERF_CNT_EN: perf_fetched,
// perf_redirects, perf_dropped
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter type T = logic [31:0],
  parameter T RESET_PC = T'(RESET_PC_DEFAULT),
  parameter T PC_INC = T'(PC_INC_DEFAULT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  T            redirect_pc,
  fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped
`endif
);
  fetch_state_e state, state_n;
  T pc, pc_n, rpc;
  fetch_out_t hold;
  logic resp, req_fire, out_fire, cap;
  assign rpc = redirect_pc & ~T'(3);
  assign resp = bus.icache_resp_valid;
  assign bus.icache_req_valid = state == REQ && !reset;
  assign bus.icache_req_addr = pc;
  // a redirect kills the held instruction in the same cycle
  assign bus.out_valid = state == HOLD && !redirect_valid && !reset;
  assign bus.out_instr = hold.instr;
  assign bus.out_pc = hold.pc;
  assign req_fire = bus.icache_req_valid && bus.icache_req_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign cap = state == WAIT && resp && !redirect_valid;
  always_comb begin
    state_n = state;
    pc_n = redirect_valid ? rpc : pc;
    case (state)
      REQ:  state_n = req_fire ? (redirect_valid ? DROP : WAIT) : REQ;
      WAIT: state_n = resp ? (redirect_valid ? REQ : HOLD) : (redirect_valid ? DROP : WAIT);
      HOLD: begin
        state_n = redirect_valid || bus.out_ready ? REQ : HOLD;
        pc_n = redirect_valid ? rpc : bus.out_ready ? pc + PC_INC : pc;
      end
      DROP: state_n = resp ? REQ : DROP;
      default: state_n = REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      hold <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (cap) hold <= '{instr: bus.icache_resp_data, pc: pc};
    end
  end
  resp_legal: assert property (@(posedge clk) disable iff (reset)
    resp |-> state inside {WAIT, DROP});
`ifdef FETCH_PERF_CNT_EN
  logic drop;
  // discarded cache response, or held instruction killed by redirect
  assign drop = (redirect_valid && (state == HOLD || (state == WAIT && resp))) ||
                (state == DROP && resp);
  fetch_perf_cnt u_perf (
    .clk(clk),
    .reset(reset),
    .fetched(out_fire),
    .redirected(redirect_valid && !reset),
    .dropped(drop),
    .perf_fetched(perf_fetched),
    .perf_redirects(perf_redirects),
    .perf_dropped(perf_dropped)
  );
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;
  import fetch_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  fetch_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_redirects, perf_dropped;
`endif
  fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_redirects(perf_redirects),
    .perf_dropped(perf_dropped)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;
  item_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  bit pend, stale, held;
  int unsigned m_fet, m_red, m_drop;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_fire actual=unexpected_pc_%h required=no_fire at %0t", bus.out_pc, $time);
        end else begin
          e = sb.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_instr", bus.out_instr, e.instr);
        end
      end
    end
  end
  initial begin
    bit directed, rr, resp, ordy, req_e;
    logic [31:0] data;
    bus.icache_req_ready = 0;
    bus.icache_resp_valid = 0;
    bus.icache_resp_data = '0;
    bus.out_ready = 0;
    m_pc = RESET_PC_DEFAULT;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      reset = cyc < 2 || cyc == 2000;
      directed = cyc < 40 || (cyc > 2000 && cyc < 2030);
      rr = directed || $urandom_range(0, 3) != 0;
      ordy = directed || (cyc >= 1000 && cyc < 1500 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 2) != 0);
      resp = !reset && pend && (directed || $urandom_range(0, 1) == 1);
      data = $urandom;
      redirect_valid = !reset && !directed && $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 5))
        0: redirect_pc = 32'h100;
        1: redirect_pc = 32'h200;
        2: redirect_pc = 32'h300;
        3: redirect_pc = 32'hFFFF_FFFC;
        4: redirect_pc = 32'hFFFF_FFF9;
        default: redirect_pc = $urandom;
      endcase
      bus.icache_req_ready = rr;
      bus.icache_resp_valid = resp;
      bus.icache_resp_data = data;
      bus.out_ready = ordy;
      @(negedge clk);
      if (reset) begin
        chk("reset_req_valid", 32'(bus.icache_req_valid), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        m_pc = RESET_PC_DEFAULT;
        pend = 0;
        stale = 0;
        held = 0;
        sb.delete();
        m_fet = 0;
        m_red = 0;
        m_drop = 0;
      end else begin
        req_e = !pend && !held;
        chk("req_valid", 32'(bus.icache_req_valid), 32'(req_e));
        if (req_e) chk("req_addr", bus.icache_req_addr, m_pc);
        chk("out_valid", 32'(bus.out_valid), 32'(held && !redirect_valid));
        if (redirect_valid) begin
          m_red++;
          if (pend && resp) begin
            pend = 0;
            m_drop++;
          end else if (pend) stale = 1;
          if (held) begin
            held = 0;
            m_drop++;
            if (sb.size() != 0) sb.pop_front();
          end
          if (req_e && rr) begin
            pend = 1;
            stale = 1;
          end
          m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (held && ordy) begin
          held = 0;
          m_pc = m_pc + 32'd4;
          m_fet++;
        end else if (pend && resp) begin
          pend = 0;
          if (stale) m_drop++;
          else begin
            sb.push_back('{pc: m_pc, instr: data});
            held = 1;
          end
        end else if (req_e && rr) begin
          pend = 1;
          stale = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 0;
    bus.icache_resp_valid = 0;
    bus.icache_req_ready = 0;
    bus.out_ready = 0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_redirects", perf_redirects, m_red);
    chk("perf_dropped", perf_dropped, m_drop);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
